// File: rtl/andla_fme0_loop_sched.sv
// Loop-nest scheduler for FME0: walks oc > oh > ow > kh > kw and issues one
// address command per kernel tap, built from incremental base registers.
module andla_fme0_loop_sched #(
    parameter int unsigned DIM_BW  = 16,
    parameter int unsigned ADDR_BW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rf_fme0_sfence,
    input  logic [DIM_BW-1:0]  rf_fme0_om_ow,
    input  logic [DIM_BW-1:0]  rf_fme0_om_oh,
    input  logic [DIM_BW-1:0]  rf_fme0_om_oc,
    input  logic [DIM_BW-1:0]  rf_fme0_im_ic,
    input  logic [7:0]         rf_fme0_im_kernel,
    input  logic [3:0]         rf_fme0_im_stride,
    input  logic [ADDR_BW-1:0] rf_fme0_im_addr_init,
    input  logic [ADDR_BW-1:0] rf_fme0_kr_addr_init,
    input  logic [ADDR_BW-1:0] rf_fme0_om_addr_init,
    input  logic [ADDR_BW-1:0] rf_fme0_im_alignment_iciw,
    input  logic [ADDR_BW-1:0] rf_fme0_om_alignment_ocow,
    input  logic [ADDR_BW-1:0] rf_fme0_alignment_kckwkh,
    input  logic [ADDR_BW-1:0] rf_fme0_alignment_kckw,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [ADDR_BW-1:0] cmd_im_addr,
    output logic [ADDR_BW-1:0] cmd_kr_addr,
    output logic [ADDR_BW-1:0] cmd_om_addr,
    output logic               cmd_last_tap,
    output logic               busy,
    output logic               done,
    output logic               rf_fme0_except_trigger
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [DIM_BW-1:0]  ow_max, oh_max, oc_max;
    logic [3:0]         kw_max, kh_max;
    logic [ADDR_BW-1:0] ic_q, iciw_q, ocow_q, kckwkh_q, kckw_q, om_oc_q;
    logic [ADDR_BW-1:0] step_col, step_row, im_init_q;

    logic [DIM_BW-1:0]  ow_cnt, oh_cnt, oc_cnt;
    logic [3:0]         kw_cnt, kh_cnt;

    logic [ADDR_BW-1:0] im_row_base, im_pix_base, im_kh_base, im_addr;
    logic [ADDR_BW-1:0] kr_oc_base, kr_kh_base, kr_addr;
    logic [ADDR_BW-1:0] om_oc_base, om_row_base, om_addr;

    logic except_q, except_hold;
    logic cfg_illegal, start, exc_req, fire;
    logic kw_wrap, kh_wrap, ow_wrap, oh_wrap, oc_wrap, final_tap;

    // Stride is at most 4 bits, so S*pitch is a fixed four-term shift-add.
    function automatic logic [ADDR_BW-1:0] scale4(input logic [ADDR_BW-1:0] v,
                                                  input logic [3:0] s);
        logic [ADDR_BW-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (s[i]) acc = acc + (v << i);
        return acc;
    endfunction

    assign cfg_illegal = (rf_fme0_om_ow == '0) || (rf_fme0_om_oh == '0) ||
                         (rf_fme0_om_oc == '0) || (rf_fme0_im_kernel[3:0] == '0) ||
                         (rf_fme0_im_kernel[7:4] == '0) || (rf_fme0_im_stride == '0);
    assign start   = rf_fme0_sfence && (state == IDLE) && !cfg_illegal;
    assign exc_req = rf_fme0_sfence && ((state != IDLE) || cfg_illegal);
    assign fire    = (state == RUN) && cmd_ready;

    assign kw_wrap   = (kw_cnt == kw_max);
    assign kh_wrap   = (kh_cnt == kh_max);
    assign ow_wrap   = (ow_cnt == ow_max);
    assign oh_wrap   = (oh_cnt == oh_max);
    assign oc_wrap   = (oc_cnt == oc_max);
    assign final_tap = fire && kw_wrap && kh_wrap && ow_wrap && oh_wrap && oc_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (final_tap) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An exception that would land on the done cycle is deferred by one cycle
    // so the two pulses never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            except_q    <= 1'b0;
            except_hold <= 1'b0;
        end else begin
            except_hold <= exc_req && (state_nxt == DONE);
            except_q    <= (exc_req && (state_nxt != DONE)) || except_hold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ow_max      <= '0;
            oh_max      <= '0;
            oc_max      <= '0;
            kw_max      <= '0;
            kh_max      <= '0;
            ic_q        <= '0;
            iciw_q      <= '0;
            ocow_q      <= '0;
            kckwkh_q    <= '0;
            kckw_q      <= '0;
            om_oc_q     <= '0;
            step_col    <= '0;
            step_row    <= '0;
            im_init_q   <= '0;
            ow_cnt      <= '0;
            oh_cnt      <= '0;
            oc_cnt      <= '0;
            kw_cnt      <= '0;
            kh_cnt      <= '0;
            im_row_base <= '0;
            im_pix_base <= '0;
            im_kh_base  <= '0;
            im_addr     <= '0;
            kr_oc_base  <= '0;
            kr_kh_base  <= '0;
            kr_addr     <= '0;
            om_oc_base  <= '0;
            om_row_base <= '0;
            om_addr     <= '0;
        end else if (start) begin
            ow_max      <= rf_fme0_om_ow - 1'b1;
            oh_max      <= rf_fme0_om_oh - 1'b1;
            oc_max      <= rf_fme0_om_oc - 1'b1;
            kw_max      <= rf_fme0_im_kernel[3:0] - 4'd1;
            kh_max      <= rf_fme0_im_kernel[7:4] - 4'd1;
            ic_q        <= ADDR_BW'(rf_fme0_im_ic);
            iciw_q      <= rf_fme0_im_alignment_iciw;
            ocow_q      <= rf_fme0_om_alignment_ocow;
            kckwkh_q    <= rf_fme0_alignment_kckwkh;
            kckw_q      <= rf_fme0_alignment_kckw;
            om_oc_q     <= ADDR_BW'(rf_fme0_om_oc);
            step_col    <= scale4(ADDR_BW'(rf_fme0_im_ic), rf_fme0_im_stride);
            step_row    <= scale4(rf_fme0_im_alignment_iciw, rf_fme0_im_stride);
            im_init_q   <= rf_fme0_im_addr_init;
            ow_cnt      <= '0;
            oh_cnt      <= '0;
            oc_cnt      <= '0;
            kw_cnt      <= '0;
            kh_cnt      <= '0;
            im_row_base <= rf_fme0_im_addr_init;
            im_pix_base <= rf_fme0_im_addr_init;
            im_kh_base  <= rf_fme0_im_addr_init;
            im_addr     <= rf_fme0_im_addr_init;
            kr_oc_base  <= rf_fme0_kr_addr_init;
            kr_kh_base  <= rf_fme0_kr_addr_init;
            kr_addr     <= rf_fme0_kr_addr_init;
            om_oc_base  <= rf_fme0_om_addr_init;
            om_row_base <= rf_fme0_om_addr_init;
            om_addr     <= rf_fme0_om_addr_init;
        end else if (fire) begin
            if (!kw_wrap) begin
                kw_cnt  <= kw_cnt + 4'd1;
                im_addr <= im_addr + ic_q;
                kr_addr <= kr_addr + ic_q;
            end else begin
                kw_cnt <= '0;
                if (!kh_wrap) begin
                    kh_cnt     <= kh_cnt + 4'd1;
                    im_kh_base <= im_kh_base + iciw_q;
                    im_addr    <= im_kh_base + iciw_q;
                    kr_kh_base <= kr_kh_base + kckw_q;
                    kr_addr    <= kr_kh_base + kckw_q;
                end else begin
                    kh_cnt     <= '0;
                    kr_kh_base <= kr_oc_base;
                    kr_addr    <= kr_oc_base;
                    if (!ow_wrap) begin
                        ow_cnt      <= ow_cnt + 1'b1;
                        im_pix_base <= im_pix_base + step_col;
                        im_kh_base  <= im_pix_base + step_col;
                        im_addr     <= im_pix_base + step_col;
                        om_addr     <= om_addr + om_oc_q;
                    end else begin
                        ow_cnt <= '0;
                        if (!oh_wrap) begin
                            oh_cnt      <= oh_cnt + 1'b1;
                            im_row_base <= im_row_base + step_row;
                            im_pix_base <= im_row_base + step_row;
                            im_kh_base  <= im_row_base + step_row;
                            im_addr     <= im_row_base + step_row;
                            om_row_base <= om_row_base + ocow_q;
                            om_addr     <= om_row_base + ocow_q;
                        end else begin
                            oh_cnt      <= '0;
                            im_row_base <= im_init_q;
                            im_pix_base <= im_init_q;
                            im_kh_base  <= im_init_q;
                            im_addr     <= im_init_q;
                            // Later assignments override the kh-level reload above.
                            if (!oc_wrap) begin
                                oc_cnt      <= oc_cnt + 1'b1;
                                kr_oc_base  <= kr_oc_base + kckwkh_q;
                                kr_kh_base  <= kr_oc_base + kckwkh_q;
                                kr_addr     <= kr_oc_base + kckwkh_q;
                                om_oc_base  <= om_oc_base + 1'b1;
                                om_row_base <= om_oc_base + 1'b1;
                                om_addr     <= om_oc_base + 1'b1;
                            end else begin
                                oc_cnt <= '0;
                            end
                        end
                    end
                end
            end
        end
    end

    assign cmd_valid              = (state == RUN);
    assign cmd_im_addr            = im_addr;
    assign cmd_kr_addr            = kr_addr;
    assign cmd_om_addr            = om_addr;
    assign cmd_last_tap           = (state == RUN) && kw_wrap && kh_wrap;
    assign busy                   = (state != IDLE);
    assign done                   = (state == DONE);
    assign rf_fme0_except_trigger = except_q;

endmodule

// File: tb/tb_andla_fme0_loop_sched.sv
// Bench for andla_fme0_loop_sched: table of loop-nest configurations checked
// against a multiply-based address model through a command scoreboard.
module tb_andla_fme0_loop_sched;

    logic        clk, rst_n, sfence;
    logic [15:0] om_ow, om_oh, om_oc, im_ic;
    logic [7:0]  im_kernel;
    logic [3:0]  im_stride;
    logic [31:0] im_init, kr_init, om_init, iciw, ocow, kckwkh, kckw;
    logic        cmd_valid, cmd_ready, cmd_last_tap, busy, done, except_trigger;
    logic [31:0] cmd_im_addr, cmd_kr_addr, cmd_om_addr;

    andla_fme0_loop_sched #(.DIM_BW(16), .ADDR_BW(32)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .rf_fme0_sfence            (sfence),
        .rf_fme0_om_ow             (om_ow),
        .rf_fme0_om_oh             (om_oh),
        .rf_fme0_om_oc             (om_oc),
        .rf_fme0_im_ic             (im_ic),
        .rf_fme0_im_kernel         (im_kernel),
        .rf_fme0_im_stride         (im_stride),
        .rf_fme0_im_addr_init      (im_init),
        .rf_fme0_kr_addr_init      (kr_init),
        .rf_fme0_om_addr_init      (om_init),
        .rf_fme0_im_alignment_iciw (iciw),
        .rf_fme0_om_alignment_ocow (ocow),
        .rf_fme0_alignment_kckwkh  (kckwkh),
        .rf_fme0_alignment_kckw    (kckw),
        .cmd_valid                 (cmd_valid),
        .cmd_ready                 (cmd_ready),
        .cmd_im_addr               (cmd_im_addr),
        .cmd_kr_addr               (cmd_kr_addr),
        .cmd_om_addr               (cmd_om_addr),
        .cmd_last_tap              (cmd_last_tap),
        .busy                      (busy),
        .done                      (done),
        .rf_fme0_except_trigger    (except_trigger)
    );

    typedef struct packed {
        logic [31:0] im;
        logic [31:0] kr;
        logic [31:0] om;
        logic        last;
    } cmd_t;

    typedef struct {
        logic [15:0] ow, oh, oc, ic;
        logic [3:0]  kh, kw, s;
        logic [31:0] im_init, kr_init, om_init, iciw, ocow, kckwkh, kckw;
        int unsigned n_cmds, spot_idx;
        cmd_t        spot;
        bit          bp;
    } vec_t;

    int unsigned checks = 0, errors = 0;
    int unsigned cyc = 0, last_hs_cyc = 0;
    int unsigned done_cnt = 0, exc_cnt = 0, done_base = 0;
    bit          bp = 0;
    bit          prev_stall = 0;
    cmd_t        prev_cmd;
    cmd_t        exp_q[$];
    cmd_t        cap[$];
    vec_t        vecs[5];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Handshake monitor: scoreboard pop, stall stability, done/except bookkeeping.
    initial begin
        cmd_t cur, e;
        forever begin
            @(negedge clk);
            cur = '{im: cmd_im_addr, kr: cmd_kr_addr, om: cmd_om_addr, last: cmd_last_tap};
            if (rst_n && prev_stall) begin
                checks++;
                if (!cmd_valid || cur !== prev_cmd) begin
                    errors++;
                    $display("FAIL stall_stable got valid=%0b %h exp valid=1 %h", cmd_valid, cur, prev_cmd);
                end
            end
            prev_stall = rst_n && cmd_valid && !cmd_ready;
            prev_cmd   = cur;
            if (cmd_valid && cmd_ready) begin
                last_hs_cyc = cyc;
                cap.push_back(cur);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_cmd got %h exp none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL cmd[%0d] got %h exp %h", cap.size() - 1, cur, e);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (cyc != last_hs_cyc + 1 || cmd_valid || !busy) begin
                    errors++;
                    $display("FAIL done_timing got cyc=%0d valid=%0b busy=%0b exp cyc=%0d valid=0 busy=1",
                             cyc, cmd_valid, busy, last_hs_cyc + 1);
                end
            end
            if (except_trigger) exc_cnt++;
            if (done || except_trigger) begin
                checks++;
                if (done && except_trigger) begin
                    errors++;
                    $display("FAIL done_except_overlap got 1 exp 0");
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned ow, oh, oc, ic, kh, kw, s,
                                input logic [31:0] imi, kri, omi, pi, po, pk, pkk,
                                input int unsigned n, idx,
                                input logic [31:0] sim, skr, som, input bit slast, input bit vbp);
        vec_t v;
        v.ow = 16'(ow); v.oh = 16'(oh); v.oc = 16'(oc); v.ic = 16'(ic);
        v.kh = 4'(kh); v.kw = 4'(kw); v.s = 4'(s);
        v.im_init = imi; v.kr_init = kri; v.om_init = omi;
        v.iciw = pi; v.ocow = po; v.kckwkh = pk; v.kckw = pkk;
        v.n_cmds = n; v.spot_idx = idx;
        v.spot = '{im: sim, kr: skr, om: som, last: slast};
        v.bp = vbp;
        return v;
    endfunction

    task automatic push_model(input vec_t v);
        cmd_t c;
        for (int unsigned a = 0; a < v.oc; a++)
            for (int unsigned b = 0; b < v.oh; b++)
                for (int unsigned w = 0; w < v.ow; w++)
                    for (int unsigned y = 0; y < v.kh; y++)
                        for (int unsigned x = 0; x < v.kw; x++) begin
                            c.im = v.im_init + (b * v.s + y) * v.iciw + (w * v.s + x) * v.ic;
                            c.kr = v.kr_init + a * v.kckwkh + y * v.kckw + x * v.ic;
                            c.om = v.om_init + b * v.ocow + w * v.oc + a;
                            c.last = (y == v.kh - 1) && (x == v.kw - 1);
                            exp_q.push_back(c);
                        end
    endtask

    task automatic set_rf(input vec_t v);
        om_ow = v.ow; om_oh = v.oh; om_oc = v.oc; im_ic = v.ic;
        im_kernel = {v.kh, v.kw}; im_stride = v.s;
        im_init = v.im_init; kr_init = v.kr_init; om_init = v.om_init;
        iciw = v.iciw; ocow = v.ocow; kckwkh = v.kckwkh; kckw = v.kckw;
    endtask

    task automatic scramble_rf();
        om_ow = 16'($urandom); om_oh = 16'($urandom); om_oc = 16'($urandom);
        im_ic = 16'($urandom); im_kernel = 8'($urandom); im_stride = 4'($urandom);
        im_init = $urandom; kr_init = $urandom; om_init = $urandom;
        iciw = $urandom; ocow = $urandom; kckwkh = $urandom; kckw = $urandom;
    endtask

    task automatic start_seq(input vec_t v);
        bp = v.bp;
        set_rf(v);
        push_model(v);
        cap.delete();
        done_base = done_cnt;
        @(posedge clk); #1; sfence = 1'b1;
        @(posedge clk); #1; sfence = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(cmd_valid), 32'd1);
        chk("first_im", cmd_im_addr, v.im_init);
        chk("first_kr", cmd_kr_addr, v.kr_init);
        chk("first_om", cmd_om_addr, v.om_init);
        scramble_rf();
    endtask

    task automatic finish_seq(input vec_t v);
        int unsigned n;
        n = 0;
        while (done_cnt == done_base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", 32'(done_cnt - done_base), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("cmd_count", 32'(cap.size()), 32'(v.n_cmds));
        checks++;
        if (cap.size() <= v.spot_idx || cap[v.spot_idx] !== v.spot) begin
            errors++;
            $display("FAIL spot[%0d] got %h exp %h", v.spot_idx,
                     (cap.size() > v.spot_idx) ? cap[v.spot_idx] : '0, v.spot);
        end
        exp_q.delete();
        bp = 0;
    endtask

    task automatic illegal_check(input vec_t v, input string name);
        int unsigned base;
        bit bad;
        set_rf(v);
        base = exc_cnt;
        @(posedge clk); #1; sfence = 1'b1;
        @(posedge clk); #1; sfence = 1'b0;
        chk({name, "_except"}, 32'(except_trigger), 32'd1);
        bad = cmd_valid || busy;
        repeat (4) begin
            @(posedge clk); #1;
            if (cmd_valid || busy || done) bad = 1;
        end
        chk({name, "_idle"}, 32'(bad), 32'd0);
        chk({name, "_pulses"}, 32'(exc_cnt - base), 32'd1);
    endtask

    initial begin
        vec_t v;
        int unsigned base;
        logic [31:0] px [9];
        rst_n = 1'b0;
        sfence = 1'b0;
        set_rf(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        //            ow oh oc ic kh kw  s  im_init       kr_init   om_init  iciw   ocow  kckwkh kckw  n  idx spot im/kr/om/last bp
        vecs[0] = mk(2, 1, 1, 4, 1, 1, 1, 32'h100,      32'h0,    32'h200, 32'h40, 32'h10, 32'h0,   32'h0,  2,   1, 32'h104, 32'h0, 32'h201, 1, 0);
        vecs[1] = mk(2, 2, 1, 1, 3, 3, 2, 32'h0,        32'h0,    32'h0,   32'd16, 32'd2,  32'd9,   32'd3, 36,  18, 32'd32,  32'h0, 32'd2,   0, 0);
        vecs[2] = mk(1, 1, 2, 4, 2, 2, 1, 32'h0,        32'h1000, 32'h300, 32'h8,  32'h20, 32'h40,  32'h10, 8,   4, 32'h0,   32'h1040, 32'h301, 0, 0);
        vecs[3] = mk(3, 3, 2, 2, 3, 3, 1, 32'h1000,     32'h2000, 32'h4000, 32'h20, 32'h40, 32'h100, 32'h10, 162, 161, 32'h1088, 32'h2124, 32'h4085, 1, 1);
        vecs[4] = mk(2, 2, 1, 3, 1, 1, 15, 32'hFFFFFF00, 32'h10,   32'h0,   32'h100, 32'h4, 32'h0,   32'h0,  4,   3, 32'hE2D, 32'h10, 32'h5,   1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_except", 32'(except_trigger), 32'd0);
        chk("rst_last", 32'(cmd_last_tap), 32'd0);
        chk("rst_im", cmd_im_addr, 32'h0);
        chk("rst_kr", cmd_kr_addr, 32'h0);
        chk("rst_om", cmd_om_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            start_seq(vecs[i]);
            finish_seq(vecs[i]);
        end

        // Illegal configurations: ow=0, kw=0, stride=0.
        v = vecs[0]; v.ow = 16'd0; illegal_check(v, "ill_ow");
        v = vecs[0]; v.kw = 4'd0;  illegal_check(v, "ill_kw");
        v = vecs[0]; v.s = 4'd0;   illegal_check(v, "ill_s");

        // sfence during RUN: exception pulse, stream unchanged.
        base = exc_cnt;
        start_seq(vecs[1]);
        repeat (4) @(posedge clk);
        #1; sfence = 1'b1;
        @(posedge clk); #1; sfence = 1'b0;
        chk("run_sfence_except", 32'(except_trigger), 32'd1);
        finish_seq(vecs[1]);
        chk("run_sfence_pulses", 32'(exc_cnt - base), 32'd1);
        px = '{32'd0, 32'd1, 32'd2, 32'd16, 32'd17, 32'd18, 32'd32, 32'd33, 32'd34};
        for (int i = 0; i < 9; i++)
            chk($sformatf("px0_im[%0d]", i), (cap.size() > 9) ? cap[i].im : 32'hX, px[i]);
        chk("px01_start", (cap.size() > 9) ? cap[9].im : 32'hX, 32'd2);

        // sfence on the final handshake cycle: pulse deferred past done.
        base = exc_cnt;
        start_seq(vecs[0]);
        @(posedge clk); #1; sfence = 1'b1;
        @(posedge clk); #1; sfence = 1'b0;
        finish_seq(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("final_sfence_pulses", 32'(exc_cnt - base), 32'd1);

        // Asynchronous reset mid-run, then a clean restart.
        start_seq(vecs[2]);
        repeat (3) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_last", 32'(cmd_last_tap), 32'd0);
        chk("mid_rst_im", cmd_im_addr, 32'h0);
        chk("mid_rst_kr", cmd_kr_addr, 32'h0);
        chk("mid_rst_om", cmd_om_addr, 32'h0);
        exp_q.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        start_seq(vecs[2]);
        finish_seq(vecs[2]);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/andla_fme0_loop_sched.md
# andla_fme0_loop_sched

Loop-nest scheduler for feature-map engine 0. On an `rf_fme0_sfence` start pulse it latches the FME0 register-file configuration, then walks the convolution loop nest `oc > oh > ow > kh > kw`. For each kernel tap it issues one command carrying the input-map, kernel and output-map byte addresses over a valid/ready interface to the FME0 datapath. It then reports completion or configuration exceptions.

## Interface
Parameters:
- `DIM_BW`, 16, width of loop-count fields (`ow`, `oh`, `oc`, `ic`).
- `ADDR_BW`, 32, width of addresses and pitches.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rf_fme0_sfence` in 1: start pulse, one cycle.
- `rf_fme0_om_ow` in `DIM_BW`: output width (count).
- `rf_fme0_om_oh` in `DIM_BW`: output height.
- `rf_fme0_om_oc` in `DIM_BW`: output channel groups.
- `rf_fme0_im_ic` in `DIM_BW`: bytes per input pixel.
- `rf_fme0_im_kernel` in 8: `{kh[7:4], kw[3:0]}`.
- `rf_fme0_im_stride` in 4: stride S, applied to both axes.
- `rf_fme0_im_addr_init` in `ADDR_BW`: input-map base address.
- `rf_fme0_kr_addr_init` in `ADDR_BW`: kernel base address.
- `rf_fme0_om_addr_init` in `ADDR_BW`: output-map base address.
- `rf_fme0_im_alignment_iciw` in `ADDR_BW`: input row pitch.
- `rf_fme0_om_alignment_ocow` in `ADDR_BW`: output row pitch.
- `rf_fme0_alignment_kckwkh` in `ADDR_BW`: per-oc kernel pitch.
- `rf_fme0_alignment_kckw` in `ADDR_BW`: per-kh kernel pitch.
- `cmd_valid` out 1: command valid.
- `cmd_ready` in 1: datapath accepts the command.
- `cmd_im_addr` out `ADDR_BW`: input-map tap address.
- `cmd_kr_addr` out `ADDR_BW`: kernel tap address.
- `cmd_om_addr` out `ADDR_BW`: output-pixel address.
- `cmd_last_tap` out 1: last tap of the current output pixel.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `rf_fme0_except_trigger` out 1: one-cycle exception pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with `sfence` and a legal configuration:
  - Latch all `rf_*` inputs into shadow registers.
  - Clear the counters and go to RUN.
  - Register-file inputs may change after this without effect.
- Illegal configuration: any of `ow`, `oh`, `oc`, `kw`, `kh`, S equal to 0.
  - `sfence` in IDLE with an illegal configuration pulses `except_trigger` and stays in IDLE.
  - No command is issued.
- RUN: `cmd_valid` = 1.
  - Each handshake (`cmd_valid && cmd_ready`) advances `kw`, carrying into `kh`, `ow`, `oh`, `oc` in that order.
- Addresses, modulo 2^`ADDR_BW`:
  - `im` = `im_init` + (oh·S + kh)·`iciw` + (ow·S + kw)·`ic`
  - `kr` = `kr_init` + oc·`kckwkh` + kh·`kckw` + kw·`ic`
  - `om` = `om_init` + oh·`ocow` + ow·`om_oc` + oc
- Address generation uses incremental adders only, with no multipliers.
  - Keep row and column base registers.
  - On each counter wrap, reload the base from the next-outer loop's base.
- `cmd_last_tap` = (kw = K_w−1) && (kh = K_h−1).
- After the handshake on the final tap (all counters at max), go to DONE.
  - DONE lasts one cycle with `done` = 1, then returns to IDLE.
- `sfence` while in RUN or DONE:
  - `except_trigger` pulses.
  - The running sequence continues unaffected, and the configuration is not re-latched.
- Total commands per start = oc·oh·ow·kh·kw.

## Timing
- Reset values: state IDLE; all outputs 0, including addresses.
- Legal `sfence` at cycle t:
  - `busy` = 1 and `cmd_valid` = 1 from t+1.
  - First command at t+1 carries the three init addresses.
- Throughput is one command per cycle while `cmd_ready` = 1.
- Stall: while `cmd_valid && !cmd_ready`, all `cmd_*` outputs stay stable. `cmd_valid` never drops before the handshake.
- Final handshake at cycle u:
  - `cmd_valid` = 0 and `done` = 1 at u+1.
  - `busy` = 0 at u+2.
  - A new `sfence` is accepted from u+2.
- `except_trigger` is asserted the cycle after the offending `sfence`.
- `done` and `except_trigger` are never asserted together.
- Asynchronous reset mid-run: state immediately returns to IDLE and all outputs go to 0. The next `sfence` restarts from the init addresses.

## Test plan
- ow=2, oh=1, oc=1, K=1×1, S=1, ic=4, im_init=0x100, om_init=0x200, ready=1:
  - im = 0x100, 0x104.
  - om = 0x200, 0x201.
  - `last_tap` on both commands; `done` one cycle after the second handshake.
- ow=oh=2, oc=1, K=3×3, S=2, ic=1, iciw=16, im_init=0:
  - First pixel im = 0, 1, 2, 16, 17, 18, 32, 33, 34.
  - Pixel (0,1) starts at 2; pixel (1,0) starts at 32.
  - `last_tap` every 9th command; 36 commands total.
- oc=2, kckwkh=0x40, kckw=0x10, K=2×2, ic=4, kr_init=0x1000:
  - oc0 kr = 0x1000, 0x1004, 0x1010, 0x1014.
  - oc1 starts at 0x1040.
- Random `cmd_ready` backpressure over 3×3×2×3×3:
  - Outputs stable during stalls.
  - Exactly 162 handshakes, with addresses matching the reference model.
- ow=0, then kw=0, then S=0, each followed by `sfence`:
  - One `except_trigger` pulse each.
  - No `cmd_valid`; `busy` stays 0.
- `sfence` during RUN:
  - `except_trigger` pulse; command stream unchanged.
- `rst_n` low mid-run:
  - All outputs 0.
  - Restart reproduces the first sequence.
